// File: rtl/lookupmac_pkg.sv
// Shared types and constants for the per-port MAC lookup initiator.
package lookupmac_pkg;

  localparam int MacW  = 48;
  localparam int PortW = 5;
  localparam int HdrW  = 2 * MacW;

  // Port mask meaning "send to every port".
  localparam logic [PortW-1:0] FLOOD = 5'b11111;

  // Receive-stream header parser states.
  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_HDR2 = 2'd1,
    P_BODY = 2'd2
  } parse_state_e;

  // Lookup request states.
  typedef enum logic {
    L_IDLE = 1'b0,
    L_WAIT = 1'b1
  } lookup_state_e;

  // One queued header: source MAC in the upper half, destination in the lower.
  typedef struct packed {
    logic [MacW-1:0] src;
    logic [MacW-1:0] dest;
  } mac_pair_t;

endpackage

// File: rtl/lookupmac_hdr_fifo.sv
// Small synchronous FIFO with full/empty flags. A push is accepted while full
// as long as a pop happens in the same cycle.
module lookupmac_hdr_fifo #(
  parameter int Width     = 96,
  parameter int DepthLog2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int Depth = 1 << DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q;
  logic [DepthLog2-1:0] rd_ptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == (DepthLog2 + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
      if (do_push && !do_pop)      count_q <= count_q + (DepthLog2 + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (DepthLog2 + 1)'(1);
    end
  end

endmodule

// File: rtl/lookupmac_req.sv
// MAC lookup initiator for one switch port: pulls dest/src MAC out of each
// received frame, queues them, runs one lookup at a time against the
// responder and hands the port mask to the scheduler.
module lookupmac_req
  import lookupmac_pkg::*;
#(
  parameter int          QDepthLog2    = 2,
  parameter logic [15:0] LookupTimeout = 16'd1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [63:0]       rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic              req,
  output logic [MacW-1:0]   src_mac,
  output logic [MacW-1:0]   dest_mac,
  input  logic              ack,
  input  logic [PortW-1:0]  forward_port,
  output logic              res_valid,
  output logic [PortW-1:0]  res_port,
  output logic              res_timeout,
  input  logic              res_ready,
  output logic [15:0]       drop_cnt
);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  parse_state_e  pstate_q;
  lookup_state_e lstate_q;
  logic [MacW-1:0]  hdr_dest_q;
  logic [15:0]      src_hi_q;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [1:0]       drop_inc;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  mac_pair_t        push_pair, head;
  logic             req_q, res_valid_q, res_timeout_q;
  logic [MacW-1:0]  src_q, dest_q;
  logic [PortW-1:0] res_port_q;
  logic [15:0]      timer_q;
  logic             rx_tail_unused;

  // Only the first 12 header bytes matter; the rest of beat 1 is payload.
  assign rx_tail_unused = ^rx_data[31:0];

  assign push_pair.src  = {src_hi_q, rx_data[63:32]};
  assign push_pair.dest = hdr_dest_q;

  // A new lookup starts only when nothing is in flight and no result is held.
  assign pop = (lstate_q == L_IDLE) && !fifo_empty && !res_valid_q;

  // Decide this beat's push and how many headers are lost (runt and/or truncated).
  always_comb begin
    push     = 1'b0;
    drop_inc = 2'd0;
    if (rx_valid) begin
      if (rx_sof) begin
        drop_inc = {1'b0, pstate_q == P_HDR2} + {1'b0, rx_eof};
      end else if (pstate_q == P_HDR2) begin
        if (fifo_full && !pop) drop_inc = 2'd1;
        else                   push     = 1'b1;
      end
    end
    drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
  end

  lookupmac_hdr_fifo #(
    .Width     (HdrW),
    .DepthLog2 (QDepthLog2)
  ) u_hdr_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst),
    .push_i  (push),
    .wdata_i (push_pair),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Capture dest MAC and the top of src MAC from every start-of-frame beat.
  always_ff @(posedge sys_clk) begin
    if (rx_valid && rx_sof) begin
      hdr_dest_q <= rx_data[63:16];
      src_hi_q   <= rx_data[15:0];
    end
  end

  // Parser FSM and drop counter; a new sof always restarts header capture.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      pstate_q   <= P_IDLE;
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (rx_valid) begin
        if (rx_sof) begin
          pstate_q <= rx_eof ? P_IDLE : P_HDR2;
        end else begin
          case (pstate_q)
            P_HDR2:  pstate_q <= rx_eof ? P_IDLE : P_BODY;
            P_BODY:  if (rx_eof) pstate_q <= P_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

  // Lookup FSM with registered request and result outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      lstate_q      <= L_IDLE;
      req_q         <= 1'b0;
      src_q         <= '0;
      dest_q        <= '0;
      timer_q       <= '0;
      res_valid_q   <= 1'b0;
      res_port_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;
      if (lstate_q == L_IDLE) begin
        if (pop) begin
          src_q    <= head.src;
          dest_q   <= head.dest;
          req_q    <= 1'b1;
          timer_q  <= '0;
          lstate_q <= L_WAIT;
        end
      end else begin
        if (ack) begin
          req_q         <= 1'b0;
          res_port_q    <= forward_port;
          res_timeout_q <= 1'b0;
          res_valid_q   <= 1'b1;
          lstate_q      <= L_IDLE;
        end else if (timer_q == LookupTimeout - 16'd1) begin
          req_q         <= 1'b0;
          res_port_q    <= FLOOD;
          res_timeout_q <= 1'b1;
          res_valid_q   <= 1'b1;
          lstate_q      <= L_IDLE;
        end else begin
          timer_q <= timer_q + 16'd1;
        end
      end
    end
  end

  assign req         = req_q;
  assign src_mac     = src_q;
  assign dest_mac    = dest_q;
  assign res_valid   = res_valid_q;
  assign res_port    = res_port_q;
  assign res_timeout = res_timeout_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_lookupmac_req.sv
// Bench for lookupmac_req: directed scenarios plus a randomized run, all
// compared cycle by cycle against a queue-based behavioural model.
module tb_lookupmac_req;

  localparam int LT    = 1023;
  localparam int QCAP  = 4;
  localparam int NEVER = 70000;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] rx_data;
  logic        rx_valid, rx_sof, rx_eof;
  logic        req;
  logic [47:0] src_mac, dest_mac;
  logic        ack;
  logic [4:0]  forward_port;
  logic        res_valid;
  logic [4:0]  res_port;
  logic        res_timeout;
  logic        res_ready;
  logic [15:0] drop_cnt;

  always #5 sys_clk = ~sys_clk;

  lookupmac_req dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .req          (req),
    .src_mac      (src_mac),
    .dest_mac     (dest_mac),
    .ack          (ack),
    .forward_port (forward_port),
    .res_valid    (res_valid),
    .res_port     (res_port),
    .res_timeout  (res_timeout),
    .res_ready    (res_ready),
    .drop_cnt     (drop_cnt)
  );

  typedef struct { bit rst; bit v; bit sof; bit eof; bit [63:0] d; } beat_t;
  beat_t beats[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Behavioural model state
  bit [95:0] m_q[$];
  bit        m_busy, m_res_valid, m_res_timeout, m_hdr2;
  bit [15:0] m_wait, m_drop, m_sh;
  bit [47:0] m_src, m_dest, m_dl;
  bit [4:0]  m_res_port;

  // Environment knobs
  int  ack_mode = 2, fix_delay = 0, resp_delay = NEVER;
  bit  spurious_en = 0, ack_manual = 0;
  int  fp_mode = 1, rr_mode = 1;
  bit [4:0] fp_val = 5'd0;

  function automatic logic [119:0] dut_vec();
    return {req, src_mac, dest_mac, res_valid, res_port, res_timeout, drop_cnt};
  endfunction

  function automatic logic [119:0] model_vec();
    return {m_busy, m_src, m_dest, m_res_valid, m_res_port, m_res_timeout, m_drop};
  endfunction

  function automatic void model_drop();
    if (m_drop != 16'hFFFF) m_drop++;
  endfunction

  // One clock of the reference behaviour, using the inputs seen at the edge.
  task automatic model_step();
    bit start;
    bit [95:0] head;
    if (!sys_rst) begin
      m_q.delete();
      m_busy = 0; m_res_valid = 0; m_res_timeout = 0; m_hdr2 = 0;
      m_wait = 0; m_drop = 0; m_src = 0; m_dest = 0; m_res_port = 0;
      return;
    end
    start = !m_busy && (m_q.size() != 0) && !m_res_valid;
    if (m_res_valid && res_ready) m_res_valid = 0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 0; m_res_valid = 1; m_res_port = forward_port; m_res_timeout = 0;
      end else if (int'(m_wait) == LT - 1) begin
        m_busy = 0; m_res_valid = 1; m_res_port = 5'b11111; m_res_timeout = 1;
      end else begin
        m_wait++;
      end
    end else if (start) begin
      head = m_q.pop_front();
      m_src = head[95:48]; m_dest = head[47:0];
      m_busy = 1; m_wait = 0;
      case (ack_mode)
        0:       resp_delay = ($urandom_range(39) == 0) ? NEVER : int'($urandom_range(6));
        1:       resp_delay = NEVER;
        default: resp_delay = fix_delay;
      endcase
    end
    if (rx_valid) begin
      if (rx_sof) begin
        if (m_hdr2) model_drop();
        if (rx_eof) model_drop();
        m_dl = rx_data[63:16];
        m_sh = rx_data[15:0];
        m_hdr2 = !rx_eof;
      end else if (m_hdr2) begin
        if (m_q.size() < QCAP) m_q.push_back({m_sh, rx_data[63:32], m_dl});
        else model_drop();
        m_hdr2 = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    cyc++;
    if (!ack_manual)
      ack = m_busy ? (int'(m_wait) == resp_delay) : (spurious_en && ($urandom_range(7) == 0));
    case (fp_mode)
      0:       forward_port = 5'($urandom());
      1:       forward_port = m_dest[4:0];
      default: forward_port = fp_val;
    endcase
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      2:       res_ready = ($urandom_range(3) == 0);
      default: ;
    endcase
  endtask

  task automatic drive(input beat_t b);
    sys_rst  = !b.rst;
    rx_valid = b.v;
    rx_sof   = b.sof;
    rx_eof   = b.eof;
    rx_data  = b.d;
  endtask

  task automatic add_idle(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.rst = 0; b.v = 0; b.sof = $urandom_range(1); b.eof = $urandom_range(1);
      b.d = {$urandom(), $urandom()};
      beats.push_back(b);
    end
  endtask

  task automatic add_frame(input bit [47:0] dest, input bit [47:0] src, input int nb,
                           input bit term, input int gap);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.rst = 0; b.v = 1; b.sof = (i == 0); b.eof = term && (i == nb - 1);
      if (i == 0)      b.d = {dest, src[47:32]};
      else if (i == 1) b.d = {src[31:0], $urandom()};
      else             b.d = {$urandom(), $urandom()};
      beats.push_back(b);
      if (gap > 0) add_idle($urandom_range(gap));
    end
  endtask

  task automatic do_reset();
    beat_t b;
    b.rst = 1; b.v = 0; b.sof = 0; b.eof = 0; b.d = '0;
    drive(b);
    tick();
    b.rst = 0;
    drive(b);
  endtask

  task automatic set_env(input int am, input int fd, input bit sp, input int fm,
                         input bit [4:0] fv, input int rm);
    ack_mode = am; fix_delay = fd; spurious_en = sp; fp_mode = fm; fp_val = fv; rr_mode = rm;
    ack_manual = 0;
  endtask

  task automatic test_reset();
    ack_manual = 1; ack = 1; res_ready = 1; forward_port = 5'h1F;
    sys_rst = 0; rx_valid = 1; rx_sof = 1; rx_eof = 0; rx_data = {$urandom(), $urandom()};
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== '0) begin
        miscompares++;
        $display("FAIL reset_state got=%h exp=0", dut_vec());
      end
    end
    ack = 0;
    sys_rst = 1; rx_valid = 0; rx_sof = 0;
    tick();
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
    end
    ack_manual = 0;
  endtask

  task automatic test_single_frame();
    beat_t b;
    int i = 0, req_cyc = -1, res_cyc = -1;
    bit [47:0] g_dest = '0, g_src = '0;
    bit [4:0]  g_port = '0;
    bit        g_to = 1'b1;
    set_env(2, 2, 0, 2, 5'b00100, 0);
    do_reset();
    add_frame(48'h001122334455, 48'h66778899AABB, 3, 1, 0);
    add_idle(10);
    while (beats.size() != 0) begin
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (req && req_cyc < 0) begin req_cyc = i + 1; g_dest = dest_mac; g_src = src_mac; end
      if (res_valid && res_cyc < 0) begin res_cyc = i + 1; g_port = res_port; g_to = res_timeout; end
      i++;
    end
    vectors++;
    if (req_cyc !== 3) begin miscompares++; $display("FAIL single_req_cycle got=%0d exp=3", req_cyc); end
    vectors++;
    if (g_dest !== 48'h001122334455) begin miscompares++; $display("FAIL single_dest got=%h exp=001122334455", g_dest); end
    vectors++;
    if (g_src !== 48'h66778899AABB) begin miscompares++; $display("FAIL single_src got=%h exp=66778899aabb", g_src); end
    vectors++;
    if (res_cyc !== 6) begin miscompares++; $display("FAIL single_res_cycle got=%0d exp=6", res_cyc); end
    vectors++;
    if (g_port !== 5'b00100 || g_to !== 1'b0) begin
      miscompares++;
      $display("FAIL single_result port=%b to=%b exp port=00100 to=0", g_port, g_to);
    end
  endtask

  task automatic test_timeout();
    beat_t b;
    int req_cnt = 0;
    set_env(1, 0, 0, 0, 5'd0, 0);
    do_reset();
    add_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 2, 1, 0);
    add_idle(LT + 20);
    while (beats.size() != 0) begin
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (req) req_cnt++;
    end
    vectors++;
    if (req_cnt !== LT) begin miscompares++; $display("FAIL timeout_req_len got=%0d exp=%0d", req_cnt, LT); end
    vectors++;
    if ({res_valid, res_port, res_timeout} !== 7'b1_11111_1) begin
      miscompares++;
      $display("FAIL timeout_result got v=%b p=%b t=%b exp v=1 p=11111 t=1", res_valid, res_port, res_timeout);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    bit [4:0] got[$];
    set_env(2, 1, 0, 1, 5'd0, 0);
    do_reset();
    for (int f = 0; f < 6; f++)
      add_frame({40'hC0FFEE0000, 8'(f + 1)}, {$urandom(), 16'(f)}, 2, 1, 0);
    add_idle(10);
    while (beats.size() != 0) begin
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL b2b_fill cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    vectors++;
    if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL b2b_drops got=%0d exp=1", drop_cnt); end
    rr_mode = 1; res_ready = 1;
    add_idle(40);
    while (beats.size() != 0) begin
      if (res_valid && res_ready) got.push_back(res_port);
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (got.size() <= k || got[k] !== 5'(k + 1)) begin
        miscompares++;
        $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", k, (got.size() > k) ? int'(got[k]) : -1, k + 1);
      end
    end
    vectors++;
    if (got.size() !== 5) begin miscompares++; $display("FAIL b2b_count got=%0d exp=5", got.size()); end
  endtask

  task automatic test_runt_truncate();
    beat_t b;
    bit [47:0] dq[$];
    bit [4:0]  rq[$];
    bit prev_req = 0;
    set_env(2, 0, 0, 1, 5'd0, 1);
    do_reset();
    add_frame(48'h10000000000A, 48'h20000000000A, 1, 1, 0);
    add_frame(48'h10000000000B, 48'h20000000000B, 3, 0, 0);
    add_frame(48'h10000000000C, 48'h20000000000C, 3, 1, 0);
    add_idle(15);
    while (beats.size() != 0) begin
      if (res_valid && res_ready) rq.push_back(res_port);
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL runt cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (req && !prev_req) dq.push_back(dest_mac);
      prev_req = req;
    end
    vectors++;
    if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL runt_drops got=%0d exp=1", drop_cnt); end
    vectors++;
    if (dq.size() != 2 || dq[0] !== 48'h10000000000B || dq[1] !== 48'h10000000000C) begin
      miscompares++;
      $display("FAIL runt_lookups got n=%0d first=%h exp n=2 10000000000b,10000000000c", dq.size(), (dq.size() > 0) ? dq[0] : 48'h0);
    end
    vectors++;
    if (rq.size() != 2 || rq[0] !== 5'h0B || rq[1] !== 5'h0C) begin
      miscompares++;
      $display("FAIL runt_results got n=%0d exp n=2 ports 0b,0c", rq.size());
    end
  endtask

  task automatic test_reset_mid_lookup();
    beat_t b;
    set_env(1, 0, 0, 0, 5'd0, 1);
    do_reset();
    add_frame(48'h3333AAAA5555, 48'h4444BBBB6666, 2, 1, 0);
    add_idle(3);
    while (beats.size() != 0) begin
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    vectors++;
    if (req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_inflight req got=%b exp=1", req); end
    ack_manual = 1; ack = 0;
    b.rst = 1; b.v = 0; b.sof = 0; b.eof = 0; b.d = '0;
    drive(b); tick();
    vectors++;
    if (dut_vec() !== '0) begin miscompares++; $display("FAIL rst_mid_clear got=%h exp=0", dut_vec()); end
    b.rst = 0; drive(b);
    for (int i = 0; i < 4; i++) begin
      ack = (i == 0);
      tick();
      vectors++;
      if (dut_vec() !== '0 || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL rst_mid_late_ack i=%0d got=%h exp=0", i, dut_vec());
      end
    end
    ack = 0; ack_manual = 0;
  endtask

  task automatic test_handshake_push();
    beat_t b;
    int i = 0, req2_cyc = -1;
    bit rv6 = 0, rv7 = 1;
    set_env(2, 0, 0, 1, 5'd0, 3);
    res_ready = 0;
    do_reset();
    add_frame(48'h5000000000A1, 48'h600000000001, 2, 1, 0);
    add_idle(3);
    add_frame(48'h5000000000B2, 48'h600000000002, 2, 1, 0);
    add_idle(8);
    while (beats.size() != 0) begin
      res_ready = (i == 6);
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL hs_push cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (i + 1 == 6) rv6 = res_valid;
      if (i + 1 == 7) rv7 = res_valid;
      if (i + 1 >= 5 && req && req2_cyc < 0) req2_cyc = i + 1;
      i++;
    end
    vectors++;
    if (rv6 !== 1'b1 || rv7 !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_clear got c6=%b c7=%b exp c6=1 c7=0", rv6, rv7);
    end
    vectors++;
    if (req2_cyc !== 8) begin miscompares++; $display("FAIL hs_next_req got=%0d exp=8", req2_cyc); end
    vectors++;
    if (res_valid !== 1'b1 || res_port !== 5'h12) begin
      miscompares++;
      $display("FAIL hs_second_result got v=%b p=%h exp v=1 p=12", res_valid, res_port);
    end
  endtask

  task automatic test_random();
    beat_t b;
    set_env(0, 0, 1, 0, 5'd0, 2);
    do_reset();
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(59) == 0) begin
        b.rst = 1; b.v = $urandom_range(1); b.sof = 1; b.eof = 0; b.d = {$urandom(), $urandom()};
        beats.push_back(b);
      end
      add_frame({$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())},
                int'($urandom_range(5, 1)), ($urandom_range(9) != 0), 2);
      add_idle($urandom_range(2));
    end
    add_idle(40);
    while (beats.size() != 0) begin
      b = beats.pop_front(); drive(b); tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    sys_rst = 0; rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_data = '0;
    ack = 0; forward_port = '0; res_ready = 0;
    test_reset();
    test_single_frame();
    test_timeout();
    test_back_to_back();
    test_runt_truncate();
    test_reset_mid_lookup();
    test_handshake_push();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
